// File: rtl/rcc_byte_packer_if.sv
`default_nettype none
// ============================================================================
// rcc_byte_packer_if : byte-in / word-out bus of the RCC byte packer (rev 1.0)
// ============================================================================
interface rcc_byte_packer_if;
  logic        i_start;
  logic [5:0]  i_RCC_BUFFER_LENGTH;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic        i_word_ready;
  logic [15:0] o_checksum;
  logic [6:0]  o_word_count;
  logic        o_busy;
  logic        o_done;
  logic        o_err_overflow;
  logic        o_err_stray;

  modport master (
    output i_start, i_RCC_BUFFER_LENGTH, i_byte, i_byte_valid, i_word_ready,
    input  o_word, o_word_valid, o_checksum, o_word_count, o_busy, o_done,
           o_err_overflow, o_err_stray
  );

  modport slave (
    input  i_start, i_RCC_BUFFER_LENGTH, i_byte, i_byte_valid, i_word_ready,
    output o_word, o_word_valid, o_checksum, o_word_count, o_busy, o_done,
           o_err_overflow, o_err_stray
  );
endinterface
`default_nettype wire

// File: rtl/rcc_byte_packer.sv
`default_nettype none
// ============================================================================
// rcc_byte_packer : packs a byte stream into 32-bit words with checksum (rev 1.0)
// ============================================================================
module rcc_byte_packer #(
  parameter int OBUF_DEPTH = 2
) (
  input  wire logic        CLK,
  input  wire logic        RESET,
  rcc_byte_packer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [5:0]  len;
  logic [1:0]  lane;
  logic [23:0] partial;
  logic [15:0] checksum;
  logic [6:0]  word_count;
  logic        err_overflow;
  logic        err_stray;

  logic [31:0] mem [OBUF_DEPTH];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  fill;

  logic        start_acc;
  logic        byte_acc;
  logic        stray;
  logic        word_done;
  logic        pop;
  logic        buf_full;
  logic        push_ok;
  logic        push_drop;
  logic        last_word;
  logic [31:0] new_word;

  always_comb begin
    start_acc = (state == S_IDLE) && bus.i_start;
    byte_acc  = (state == S_RUN) && bus.i_byte_valid;
    stray     = (state != S_RUN) && bus.i_byte_valid;
    word_done = byte_acc && (lane == 2'd3);
    new_word  = {bus.i_byte, partial};
    pop       = (fill != 2'd0) && bus.i_word_ready;
    buf_full  = (fill == 2'(OBUF_DEPTH));
    // A pop frees the head slot in the same edge, so a full buffer still takes the push.
    push_ok   = word_done && (!buf_full || pop);
    push_drop = word_done && buf_full && !pop;
    last_word = word_done && ((word_count + 7'd1) == {1'b0, len});
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.i_start) begin
          state_nxt = (bus.i_RCC_BUFFER_LENGTH != 6'd0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (last_word) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fill == 2'd0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_busy         = (state == S_RUN) || (state == S_DRAIN);
    bus.o_done         = (state == S_DONE);
    bus.o_word_valid   = (fill != 2'd0);
    bus.o_word         = (fill != 2'd0) ? mem[rd_ptr] : 32'd0;
    bus.o_checksum     = checksum;
    bus.o_word_count   = word_count;
    bus.o_err_overflow = err_overflow;
    bus.o_err_stray    = err_stray;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      len          <= 6'd0;
      lane         <= 2'd0;
      partial      <= 24'd0;
      checksum     <= 16'd0;
      word_count   <= 7'd0;
      err_overflow <= 1'b0;
      err_stray    <= 1'b0;
    end else begin
      if (start_acc) begin
        len          <= bus.i_RCC_BUFFER_LENGTH;
        lane         <= 2'd0;
        checksum     <= 16'd0;
        word_count   <= 7'd0;
        err_overflow <= 1'b0;
        err_stray    <= 1'b0;
      end
      if (byte_acc) begin
        lane     <= lane + 2'd1;
        checksum <= checksum + {8'd0, bus.i_byte};
        case (lane)
          2'd0:    partial[7:0]   <= bus.i_byte;
          2'd1:    partial[15:8]  <= bus.i_byte;
          2'd2:    partial[23:16] <= bus.i_byte;
          default: ;
        endcase
      end
      if (word_done) begin
        word_count <= word_count + 7'd1;
      end
      if (push_drop) begin
        err_overflow <= 1'b1;
      end
      // Set after the start clear so a byte in the start cycle still flags.
      if (stray) begin
        err_stray <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      fill   <= 2'd0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop})
        2'b10:   fill <= fill + 2'd1;
        2'b01:   fill <= fill - 2'd1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= new_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rcc_byte_packer.sv
`default_nettype none
// tb_rcc_byte_packer : directed self-checking bench for rcc_byte_packer.
module tb_rcc_byte_packer;
  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pops;
  int   dones;
  int   vseen;

  rcc_byte_packer_if bus();

  rcc_byte_packer #(.OBUF_DEPTH(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_word"},     bus.o_word, 32'd0);
    chk({tag, "_valid"},    32'(bus.o_word_valid), 32'd0);
    chk({tag, "_checksum"}, 32'(bus.o_checksum), 32'd0);
    chk({tag, "_count"},    32'(bus.o_word_count), 32'd0);
    chk({tag, "_busy"},     32'(bus.o_busy), 32'd0);
    chk({tag, "_done"},     32'(bus.o_done), 32'd0);
    chk({tag, "_ovf"},      32'(bus.o_err_overflow), 32'd0);
    chk({tag, "_stray"},    32'(bus.o_err_stray), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_start = 1'b0;
    bus.i_RCC_BUFFER_LENGTH = 6'd0;
    bus.i_byte = 8'd0;
    bus.i_byte_valid = 1'b0;
    bus.i_word_ready = 1'b0;
    repeat (3) tick();
    RESET = 1'b0;
    chk_all_zero("reset");

    // len=2, bytes 1..8 back-to-back, ready held high
    bus.i_word_ready = 1'b1;
    bus.i_start = 1'b1;
    bus.i_RCC_BUFFER_LENGTH = 6'd2;
    tick();
    bus.i_start = 1'b0;
    chk("t1_busy", 32'(bus.o_busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      bus.i_byte = 8'(i + 1);
      bus.i_byte_valid = 1'b1;
      tick();
      if (i == 3) begin
        chk("t1_word0", bus.o_word, 32'h04030201);
        chk("t1_valid0", 32'(bus.o_word_valid), 32'd1);
        chk("t1_count1", 32'(bus.o_word_count), 32'd1);
      end
    end
    bus.i_byte_valid = 1'b0;
    chk("t1_word1", bus.o_word, 32'h08070605);
    chk("t1_checksum", 32'(bus.o_checksum), 32'h0024);
    chk("t1_count2", 32'(bus.o_word_count), 32'd2);
    tick();
    chk("t1_empty", 32'(bus.o_word_valid), 32'd0);
    chk("t1_no_early_done", 32'(bus.o_done), 32'd0);
    tick();
    chk("t1_done", 32'(bus.o_done), 32'd1);
    chk("t1_busy_low", 32'(bus.o_busy), 32'd0);
    tick();
    chk("t1_done_once", 32'(bus.o_done), 32'd0);
    chk("t1_ovf", 32'(bus.o_err_overflow), 32'd0);
    chk("t1_stray", 32'(bus.o_err_stray), 32'd0);

    // len=3, 12 bytes with ready low: third word dropped
    bus.i_word_ready = 1'b0;
    bus.i_start = 1'b1;
    bus.i_RCC_BUFFER_LENGTH = 6'd3;
    tick();
    bus.i_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.i_byte = 8'(16 + i);
      bus.i_byte_valid = 1'b1;
      tick();
      if (i == 3) begin
        chk("t2_word0", bus.o_word, 32'h13121110);
      end
    end
    bus.i_byte_valid = 1'b0;
    chk("t2_head_held", bus.o_word, 32'h13121110);
    chk("t2_ovf", 32'(bus.o_err_overflow), 32'd1);
    chk("t2_count", 32'(bus.o_word_count), 32'd3);
    chk("t2_checksum", 32'(bus.o_checksum), 32'h0102);
    chk("t2_busy", 32'(bus.o_busy), 32'd1);
    bus.i_word_ready = 1'b1;
    tick();
    chk("t2_word1", bus.o_word, 32'h17161514);
    chk("t2_valid1", 32'(bus.o_word_valid), 32'd1);
    tick();
    chk("t2_empty", 32'(bus.o_word_valid), 32'd0);
    chk("t2_no_early_done", 32'(bus.o_done), 32'd0);
    tick();
    chk("t2_done", 32'(bus.o_done), 32'd1);
    bus.i_word_ready = 1'b0;
    tick();
    chk("t2_done_once", 32'(bus.o_done), 32'd0);
    chk("t2_ovf_sticky", 32'(bus.o_err_overflow), 32'd1);

    // len=1, 0xFF x4, ready toggling every cycle
    bus.i_start = 1'b1;
    bus.i_RCC_BUFFER_LENGTH = 6'd1;
    tick();
    bus.i_start = 1'b0;
    chk("t3_ovf_cleared", 32'(bus.o_err_overflow), 32'd0);
    bus.i_word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_byte = 8'hFF;
      bus.i_byte_valid = 1'b1;
      tick();
    end
    bus.i_byte_valid = 1'b0;
    chk("t3_word", bus.o_word, 32'hFFFFFFFF);
    chk("t3_checksum", 32'(bus.o_checksum), 32'h03FC);
    pops = 0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      bus.i_word_ready = ~bus.i_word_ready;
      if (bus.o_word_valid && bus.i_word_ready) pops++;
      if (bus.o_done) dones++;
      tick();
    end
    bus.i_word_ready = 1'b0;
    chk("t3_pops", 32'(pops), 32'd1);
    chk("t3_dones", 32'(dones), 32'd1);

    // stray bytes in IDLE, then a stray byte on the start cycle
    bus.i_byte = 8'hAA;
    bus.i_byte_valid = 1'b1;
    tick();
    tick();
    bus.i_byte_valid = 1'b0;
    chk("t4_stray", 32'(bus.o_err_stray), 32'd1);
    chk("t4_checksum_kept", 32'(bus.o_checksum), 32'h03FC);
    chk("t4_count_kept", 32'(bus.o_word_count), 32'd1);
    chk("t4_no_word", 32'(bus.o_word_valid), 32'd0);
    bus.i_start = 1'b1;
    bus.i_RCC_BUFFER_LENGTH = 6'd1;
    bus.i_byte = 8'h55;
    bus.i_byte_valid = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_byte_valid = 1'b0;
    chk("t4_stray_on_start", 32'(bus.o_err_stray), 32'd1);
    chk("t4_checksum_clr", 32'(bus.o_checksum), 32'd0);
    chk("t4_count_clr", 32'(bus.o_word_count), 32'd0);
    bus.i_word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_byte = 8'(i + 1);
      bus.i_byte_valid = 1'b1;
      tick();
    end
    bus.i_byte_valid = 1'b0;
    chk("t4_word", bus.o_word, 32'h04030201);
    chk("t4_checksum", 32'(bus.o_checksum), 32'h000A);
    tick();
    tick();
    chk("t4_done", 32'(bus.o_done), 32'd1);
    tick();

    // len=0: immediate completion, no word
    bus.i_word_ready = 1'b0;
    bus.i_start = 1'b1;
    bus.i_RCC_BUFFER_LENGTH = 6'd0;
    chk("t5_done_pre", 32'(bus.o_done), 32'd0);
    tick();
    bus.i_start = 1'b0;
    dones = 0;
    vseen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.o_done) dones++;
      if (bus.o_word_valid) vseen++;
      tick();
    end
    chk("t5_dones", 32'(dones), 32'd1);
    chk("t5_no_valid", 32'(vseen), 32'd0);
    chk("t5_idle", 32'(bus.o_busy), 32'd0);

    // reset mid-transfer after 6 bytes of len=4
    bus.i_start = 1'b1;
    bus.i_RCC_BUFFER_LENGTH = 6'd4;
    tick();
    bus.i_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.i_byte = 8'(8'h21 + i);
      bus.i_byte_valid = 1'b1;
      tick();
    end
    bus.i_byte_valid = 1'b0;
    chk("t6_pre_valid", 32'(bus.o_word_valid), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_all_zero("t6_reset");
    tick();
    chk("t6_no_done", 32'(bus.o_done), 32'd0);
    bus.i_word_ready = 1'b1;
    bus.i_start = 1'b1;
    bus.i_RCC_BUFFER_LENGTH = 6'd1;
    tick();
    bus.i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_byte = 8'(8'h11 * (i + 1));
      bus.i_byte_valid = 1'b1;
      tick();
    end
    bus.i_byte_valid = 1'b0;
    chk("t6_word", bus.o_word, 32'h44332211);
    chk("t6_checksum", 32'(bus.o_checksum), 32'h00AA);
    tick();
    tick();
    chk("t6_done", 32'(bus.o_done), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
